// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The borrow_in signal exists only when SERIAL_SUB_BORROW_IN_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
`ifdef SERIAL_SUB_BORROW_IN_EN
    logic             borrow_in;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;

`ifdef SERIAL_SUB_BORROW_IN_EN
    modport master (
        output start, a_in, b_in, borrow_in,
        input  busy, done, diff_out, borrow_out
    );
    modport slave (
        input  start, a_in, b_in, borrow_in,
        output busy, done, diff_out, borrow_out
    );
`else
    modport master (
        output start, a_in, b_in,
        input  busy, done, diff_out, borrow_out
    );
    modport slave (
        input  start, a_in, b_in,
        output busy, done, diff_out, borrow_out
    );
`endif

endinterface

// File: rtl/serial_subtractor_fullsubractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bor set when the
// subtraction needs to borrow from the next bit.
module fullsubractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bor
);

    // Purely combinational difference and borrow generation.
    always_comb begin
        diff = a ^ b ^ bin;
        bor  = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, using a single
// fullsubractor cell fed from a registered borrow.
// Optional macro SERIAL_SUB_BORROW_IN_EN adds bus.borrow_in, loaded into the
// borrow register on the accepted start so words can be chained.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; outputs hold the previous result
// S_RUN  | one result bit per edge, WIDTH edges
// S_DONE | done pulse for one cycle, then back to S_IDLE
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the upper WIDTH-1 result bits need storing; the newest bit comes
    // straight from the cell on the final edge.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             cell_diff;
    logic             cell_bor;
    logic             borrow_load;

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign borrow_load = bus.borrow_in;
`else
    assign borrow_load = 1'b0;
`endif

    fullsubractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .diff (cell_diff),
        .bor  (cell_bor)
    );

    assign res_next = {cell_diff, res_sh};

    // Sequencing, datapath shifting and registered handshake/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a_in;
                        b_sh   <= bus.b_in;
                        borrow <= borrow_load;
                        cnt    <= '0;
                        res_sh <= '0;
                        busy_r <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next[WIDTH-1:1];
                    borrow <= cell_bor;
                    if (cnt == CNT_LAST) begin
                        diff_r   <= res_next;
                        borrow_r <= cell_bor;
                        done_r   <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.diff_out   = diff_r;
    assign bus.borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed table-driven bench for serial_subtractor (WIDTH=8), plus
// hand-written sequences for ignored start, mid-operation reset and
// continuous start.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t vecs[$];

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] prev_diff;
    logic         prev_bo;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_bin(input logic v);
`ifdef SERIAL_SUB_BORROW_IN_EN
        bus.borrow_in = v;
`else
        if (v) $display("note: borrow_in ignored in this build");
`endif
    endtask

    // Launch one operation and follow it to completion. inject_at >= 0 pulses
    // a second start with different operands at that RUN cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb, input int inject_at,
                          input string nm);
        int lat;
        int busy_cnt;
        int done_cnt;
        int done_lat;
        @(negedge clk);
        bus.a_in  = a;
        bus.b_in  = b;
        set_bin(bin);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = b ^ 8'h5A;
        lat = 0; busy_cnt = 0; done_cnt = 0; done_lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_lat = lat;
            end
            if (lat == 4) begin
                check({nm, " hold_diff"}, 32'(bus.diff_out), 32'(prev_diff));
                check({nm, " hold_borrow"}, 32'(bus.borrow_out), 32'(prev_bo));
            end
            if (!bus.busy) break;
            if (lat == inject_at) begin
                bus.start = 1'b1;
                bus.a_in  = 8'hC3;
                bus.b_in  = 8'h3C;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({nm, " done_count"}, 32'(done_cnt), 32'd1);
        check({nm, " latency"}, 32'(done_lat), 32'(W));
        check({nm, " busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
        check({nm, " diff"}, 32'(bus.diff_out), 32'(ed));
        check({nm, " borrow"}, 32'(bus.borrow_out), 32'(eb));
        prev_diff = ed;
        prev_bo   = eb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dcnt;
        int bcnt;

        vecs.push_back('{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0});
        vecs.push_back('{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0});
        vecs.push_back('{8'h01, 8'h80, 1'b0, 8'h81, 1'b1});
        vecs.push_back('{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0});
`ifdef SERIAL_SUB_BORROW_IN_EN
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{8'h05, 8'h02, 1'b1, 8'h02, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0});
`endif

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        set_bin(1'b0);
        prev_diff = '0;
        prev_bo   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset diff", 32'(bus.diff_out), 32'd0);
        check("reset borrow", 32'(bus.borrow_out), 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, -1,
                   $sformatf("vec%0d", i));

        // Second start during RUN must be ignored.
        run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 3, "ignored_start");

        // Reset in the middle of an operation aborts it without a done pulse.
        @(negedge clk);
        bus.a_in  = 8'h33;
        bus.b_in  = 8'h11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst diff", 32'(bus.diff_out), 32'd0);
        check("midrst borrow", 32'(bus.borrow_out), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
            if (bus.busy) bcnt++;
        end
        check("midrst no_done", 32'(dcnt), 32'd0);
        check("midrst no_busy", 32'(bcnt), 32'd0);
        prev_diff = '0;
        prev_bo   = 1'b0;
        run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, -1, "after_rst");

        // Start held high keeps re-triggering from IDLE.
        @(negedge clk);
        bus.a_in  = 8'h03;
        bus.b_in  = 8'h01;
        bus.start = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        bus.start = 1'b0;
        check("retrigger done_count", 32'(dcnt), 32'd3);
        check("retrigger diff", 32'(bus.diff_out), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
